// File: rtl/vedic_pp_combiner.sv
// Sequential combiner for the four 8x8 Vedic partial products of a 16x16 multiply.
// One time-shared CLA16 reduces them in three passes (MID, LO, HI).

module vedic_cla16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = x & y;
    assign p = x ^ y;

    // Group generate/propagate for the four 4-bit lookahead blocks.
    // NOTE: every signal written in an always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int i = 0; i < 4; i++) begin
            gp[i] = &p[4*i +: 4];
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        end
    end

    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    always_comb begin
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[4];
endmodule

module vedic_pp_combiner #(
    parameter int PP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   pp_ll,
    input  logic [PP_W-1:0]   pp_hl,
    input  logic [PP_W-1:0]   pp_lh,
    input  logic [PP_W-1:0]   pp_hh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*PP_W-1:0] product,
    output logic              ovf
);
    generate
        if (PP_W != 16) begin : g_bad_width
            $error("vedic_pp_combiner: PP_W must be 16 (adder is a CLA16)");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MID  = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PP_W-1:0]     ll_q, ll_d;
    logic [PP_W-1:0]     hl_q, hl_d;
    logic [PP_W-1:0]     lh_q, lh_d;
    logic [PP_W-1:0]     hh_q, hh_d;
    logic [PP_W-1:0]     mid_q, mid_d;
    logic                c_mid_q, c_mid_d;
    logic                c1_q, c1_d;
    logic [2*PP_W-1:0]   product_q, product_d;
    logic                ovf_q, ovf_d;

    logic [15:0]         add_x;
    logic [15:0]         add_y;
    logic                add_cin;
    logic [15:0]         add_sum;
    logic                add_cout;

    // Operand mux for the single shared adder, steered by the pass in progress.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            MID: begin
                add_x = hl_q;
                add_y = lh_q;
            end
            LO: begin
                add_x = ll_q;
                add_y = {mid_q[7:0], 8'h00};
            end
            HI: begin
                add_x   = hh_q;
                add_y   = {7'b0, c_mid_q, mid_q[15:8]};
                add_cin = c1_q;
            end
            default: ;
        endcase
    end

    vedic_cla16 u_cla (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        ll_d      = ll_q;
        hl_d      = hl_q;
        lh_d      = lh_q;
        hh_d      = hh_q;
        mid_d     = mid_q;
        c_mid_d   = c_mid_q;
        c1_d      = c1_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ll_d    = pp_ll;
                    hl_d    = pp_hl;
                    lh_d    = pp_lh;
                    hh_d    = pp_hh;
                    state_d = MID;
                end
            end
            MID: begin
                mid_d   = add_sum;
                c_mid_d = add_cout;
                state_d = LO;
            end
            LO: begin
                product_d[15:0] = add_sum;
                c1_d            = add_cout;
                state_d         = HI;
            end
            HI: begin
                product_d[31:16] = add_sum;
                ovf_d            = add_cout;
                state_d          = DONE;
            end
            DONE: begin
                // Result stays in product_q after acceptance; out_valid alone qualifies it.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ll_q      <= '0;
            hl_q      <= '0;
            lh_q      <= '0;
            hh_q      <= '0;
            mid_q     <= '0;
            c_mid_q   <= 1'b0;
            c1_q      <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ll_q      <= ll_d;
            hl_q      <= hl_d;
            lh_q      <= lh_d;
            hh_q      <= hh_d;
            mid_q     <= mid_d;
            c_mid_q   <= c_mid_d;
            c1_q      <= c1_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign ovf       = ovf_q;
endmodule
